// File: rtl/music_seq_ctrl_if.sv
// Bundle of the sequencer's control, loader and note-RAM signals.
// The slave modport is the sequencer's view; master is the surrounding system.
interface music_seq_ctrl_if #(
  parameter int DATA_WDTH = 5,
  parameter int COL_BITS  = 8
);
  logic                 start;
  logic                 stop;
  logic [COL_BITS-1:0]  song_len;
  logic                 wr_req;
  logic [COL_BITS-1:0]  wr_addr;
  logic [DATA_WDTH-1:0] wr_data;
  logic                 wr_ack;
  logic [COL_BITS-1:0]  ram_addra;
  logic [DATA_WDTH-1:0] ram_dina;
  logic                 ram_wen;
  logic [COL_BITS-1:0]  ram_addrb;
  logic [DATA_WDTH-1:0] ram_doutb;
  logic [DATA_WDTH-1:0] note;
  logic                 note_valid;
  logic                 playing;
  logic                 done;

  modport master (
    output start, stop, song_len, wr_req, wr_addr, wr_data, ram_doutb,
    input  wr_ack, ram_addra, ram_dina, ram_wen, ram_addrb,
           note, note_valid, playing, done
  );

  modport slave (
    input  start, stop, song_len, wr_req, wr_addr, wr_data, ram_doutb,
    output wr_ack, ram_addra, ram_dina, ram_wen, ram_addrb,
           note, note_valid, playing, done
  );
endinterface

// File: rtl/music_seq_ctrl.sv
// Note-RAM playback sequencer with loader write-port arbitration.
// Optional feature macro: MUSIC_LOOP_EN (endless looping playback).
module music_seq_ctrl #(
  parameter int DATA_WDTH = 5,
  parameter int COL       = 100,
  parameter int COL_BITS  = 8,
  parameter int BEAT_CNT  = 3000000,
  parameter int GAP_CNT   = 300000
) (
  input  logic             clk,
  input  logic             rst,
  music_seq_ctrl_if.slave  bus
);

  localparam int BEAT_W = $clog2(BEAT_CNT + 1);
  localparam int GAP_W  = (GAP_CNT > 0) ? $clog2(GAP_CNT + 1) : 1;
  localparam logic [BEAT_W-1:0]   BEAT_LOAD = BEAT_W'(BEAT_CNT - 1);
  localparam logic [GAP_W-1:0]    GAP_LOAD  = GAP_W'((GAP_CNT > 0) ? GAP_CNT - 1 : 0);
  localparam logic [COL_BITS-1:0] PTR_ONE   = COL_BITS'(1);
  // Longest song the RAM can actually hold at this address width
  localparam logic [COL_BITS-1:0] LEN_MAX   =
    COL_BITS'((COL >= (1 << COL_BITS)) ? (1 << COL_BITS) - 1 : COL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               r_state;
  logic [COL_BITS-1:0]  r_ptr;
  logic [COL_BITS-1:0]  r_len;
  logic [DATA_WDTH-1:0] r_note;
  logic [BEAT_W-1:0]    r_beat;
  logic [GAP_W-1:0]     r_gap;
  logic                 r_done;

  state_t               w_state_next;
  logic [COL_BITS-1:0]  w_ptr_next;
  logic [COL_BITS-1:0]  w_len_next;
  logic [DATA_WDTH-1:0] w_note_next;
  logic [BEAT_W-1:0]    w_beat_next;
  logic [GAP_W-1:0]     w_gap_next;
  logic                 w_done_next;
  logic                 w_adv;
  logic                 w_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_note  <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_len   <= w_len_next;
      r_note  <= w_note_next;
      r_beat  <= w_beat_next;
      r_gap   <= w_gap_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_len_next   = r_len;
    w_note_next  = r_note;
    w_beat_next  = r_beat;
    w_gap_next   = r_gap;
    w_done_next  = 1'b0;
    w_adv        = 1'b0;
    w_end        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_len_next = (bus.song_len > LEN_MAX) ? LEN_MAX : bus.song_len;
          w_ptr_next = '0;
          if (bus.song_len != '0) begin
            w_state_next = S_FETCH;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      S_FETCH: begin
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        // All-ones code marks the end of the stored song and is never sounded
        if (&bus.ram_doutb) begin
          w_end = 1'b1;
        end else begin
          w_note_next  = bus.ram_doutb;
          w_beat_next  = BEAT_LOAD;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_beat == '0) begin
          if (GAP_CNT == 0) begin
            w_adv = 1'b1;
          end else begin
            w_gap_next   = GAP_LOAD;
            w_state_next = S_GAP;
          end
        end else begin
          w_beat_next = r_beat - 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_adv = 1'b1;
        end else begin
          w_gap_next = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_adv) begin
      if (r_ptr == r_len - PTR_ONE) begin
        w_end = 1'b1;
      end else begin
        w_ptr_next   = r_ptr + PTR_ONE;
        w_state_next = S_FETCH;
      end
    end

    if (w_end) begin
      w_done_next = 1'b1;
      w_ptr_next  = '0;
`ifdef MUSIC_LOOP_EN
      w_state_next = S_FETCH;
`else
      w_state_next = S_IDLE;
`endif
    end

    // Abort dominates everything, including a coincident end of song
    if (bus.stop) begin
      w_state_next = S_IDLE;
      w_ptr_next   = '0;
      w_done_next  = 1'b0;
    end
  end

  assign bus.wr_ack     = bus.wr_req & (r_state != S_FETCH) & ~rst;
  assign bus.ram_wen    = bus.wr_ack;
  assign bus.ram_addra  = bus.wr_addr;
  assign bus.ram_dina   = bus.wr_data;
  assign bus.ram_addrb  = r_ptr;
  assign bus.note       = r_note;
  assign bus.note_valid = (r_state == S_HOLD) && (r_note != '0);
  assign bus.playing    = (r_state != S_IDLE);
  assign bus.done       = r_done;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Randomized and directed bench for music_seq_ctrl against a per-cycle
// timeline model derived from the note list; covers both loop builds.
module tb_music_seq_ctrl;

  localparam int DW   = 5;
  localparam int CB   = 3;
  localparam int COLN = 8;
  localparam int B    = 4;
  localparam int G    = 1;
  localparam int MAXS = 256;
`ifdef MUSIC_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  music_seq_ctrl_if #(.DATA_WDTH(DW), .COL_BITS(CB)) bus ();

  music_seq_ctrl #(
    .DATA_WDTH(DW), .COL(COLN), .COL_BITS(CB), .BEAT_CNT(B), .GAP_CNT(G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Note RAM: registered read, output held during a write
  logic [DW-1:0] ram [COLN];
  always @(posedge clk) begin
    if (bus.ram_wen) ram[bus.ram_addra] <= bus.ram_dina;
    else             bus.ram_doutb <= ram[bus.ram_addrb];
  end

  int mem_model [COLN];
  int e_play [MAXS];
  int e_valid[MAXS];
  int e_note [MAXS];
  int e_done [MAXS];
  int e_fetch[MAXS];
  int e_addr [MAXS];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs per cycle, step 0 = first cycle after start is sampled
  task automatic build_model(input int len, input bit loop, input int steps, input int stop_step);
    int t, i, code, endp;
    bit fin;
    for (int k = 0; k < MAXS; k++) begin
      e_play[k] = 0; e_valid[k] = 0; e_note[k] = 0;
      e_done[k] = 0; e_fetch[k] = 0; e_addr[k] = 0;
    end
    if (len == 0) begin
      e_done[0] = 1;
    end else begin
      t = 0; i = 0; fin = 1'b0;
      while (!fin && t < steps) begin
        code = mem_model[i];
        e_play[t] = 1; e_fetch[t] = 1; e_addr[t] = i;
        e_play[t+1] = 1;
        if (code == 31) begin
          endp = t + 2;
        end else begin
          for (int k = 0; k < B; k++) begin
            e_play[t+2+k]  = 1;
            e_valid[t+2+k] = (code != 0) ? 1 : 0;
            e_note[t+2+k]  = code;
          end
          for (int k = 0; k < G; k++) e_play[t+2+B+k] = 1;
          endp = t + 2 + B + G;
          if (i != len - 1) begin
            i++;
            t = endp;
            continue;
          end
        end
        e_done[endp] = 1;
        if (loop) begin
          i = 0;
          t = endp;
        end else begin
          fin = 1'b1;
        end
      end
    end
    if (stop_step >= 0) begin
      for (int k = stop_step + 1; k < MAXS; k++) begin
        e_play[k] = 0; e_valid[k] = 0; e_done[k] = 0; e_fetch[k] = 0;
      end
    end
  endtask

  task automatic load_word(input int a, input int d);
    bit ok;
    ok = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a[CB-1:0];
    bus.wr_data = d[DW-1:0];
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (bus.wr_ack) ok = 1'b1;
      @(negedge clk);
    end
    bus.wr_req = 1'b0;
    check("load_ack", int'(ok), 1);
    mem_model[a] = d;
  endtask

  task automatic run_song(input string name, input int len, input int steps, input int stop_step,
                          input int wr_step, input int wr_a, input int wr_d);
    int dummy;
    if (wr_step >= 0) mem_model[wr_a] = wr_d;
    build_model(len, LOOP, steps, stop_step);
    dummy = mem_model[7];
    $display("song %s: len=%0d steps=%0d stop@%0d", name, len, steps, stop_step);
    bus.start    = 1'b1;
    bus.song_len = len[CB-1:0];
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 3'd7;
    bus.wr_data  = dummy[DW-1:0];
    @(negedge clk);
    bus.start    = 1'b0;
    bus.song_len = CB'($urandom_range(0, 7));
    for (int t = 0; t < steps; t++) begin
      check($sformatf("%s.playing@%0d", name, t), int'(bus.playing), e_play[t]);
      check($sformatf("%s.valid@%0d", name, t), int'(bus.note_valid), e_valid[t]);
      check($sformatf("%s.done@%0d", name, t), int'(bus.done), e_done[t]);
      check($sformatf("%s.wr_ack@%0d", name, t), int'(bus.wr_ack), 1 - e_fetch[t]);
      if (e_valid[t] != 0)
        check($sformatf("%s.note@%0d", name, t), int'(bus.note), e_note[t]);
      if (e_fetch[t] != 0)
        check($sformatf("%s.addrb@%0d", name, t), int'(bus.ram_addrb), e_addr[t]);
      bus.stop = (t == stop_step);
      if (t == wr_step) begin
        bus.wr_addr = wr_a[CB-1:0];
        bus.wr_data = wr_d[DW-1:0];
      end else begin
        bus.wr_addr = 3'd7;
        bus.wr_data = dummy[DW-1:0];
      end
      @(negedge clk);
    end
    bus.stop   = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic load_song(input int c0, input int c1, input int c2);
    load_word(0, c0);
    load_word(1, c1);
    load_word(2, c2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, code, r;
    bus.start = 1'b0; bus.stop = 1'b0; bus.song_len = '0;
    bus.wr_req = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
    for (int a = 0; a < COLN; a++) mem_model[a] = 0;
    repeat (2) @(negedge clk);
    check("rst.wr_ack", int'(bus.wr_ack), 0);
    check("rst.note", int'(bus.note), 0);
    check("rst.valid", int'(bus.note_valid), 0);
    check("rst.playing", int'(bus.playing), 0);
    check("rst.done", int'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.wr_ack", int'(bus.wr_ack), 1);
    check("idle.addrb", int'(bus.ram_addrb), 0);
    bus.wr_req = 1'b0;
    load_word(7, 0);

    // Basic playback, then loader write into a note not yet fetched
    load_song(3, 5, 7);
    run_song("basic", 3, 26, 23, -1, 0, 0);
    run_song("wr9", 3, 26, 23, 3, 2, 9);

    // Reset pulse in the middle of a held note
    load_song(3, 5, 7);
    $display("song reset: len=3 rst at step 4");
    bus.start = 1'b1; bus.song_len = 3'd3; bus.wr_req = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = '0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst.valid_before", int'(bus.note_valid), 1);
    rst = 1'b1;
    #1;
    check("midrst.note", int'(bus.note), 0);
    check("midrst.valid", int'(bus.note_valid), 0);
    check("midrst.playing", int'(bus.playing), 0);
    check("midrst.done", int'(bus.done), 0);
    check("midrst.wr_ack", int'(bus.wr_ack), 0);
    check("midrst.addrb", int'(bus.ram_addrb), 0);
    @(negedge clk);
    rst = 1'b0; bus.wr_req = 1'b0;
    @(negedge clk);
    check("postrst.playing", int'(bus.playing), 0);
    check("postrst.addrb", int'(bus.ram_addrb), 0);

    // End marker and rest
    load_song(4, 0, 31);
    run_song("marker", 3, 20, 17, -1, 0, 0);

    // Stop right after the first note starts sounding
    load_song(3, 5, 7);
    run_song("stop", 3, 10, 3, -1, 0, 0);

    // Simultaneous start and stop must not start playback
    $display("song startstop: len=3");
    bus.start = 1'b1; bus.stop = 1'b1; bus.song_len = 3'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int t = 0; t < 5; t++) begin
      check($sformatf("startstop.playing@%0d", t), int'(bus.playing), 0);
      check($sformatf("startstop.done@%0d", t), int'(bus.done), 0);
      @(negedge clk);
    end

    // Zero-length song only pulses done
    run_song("len0", 0, 5, -1, -1, 0, 0);

`ifdef MUSIC_LOOP_EN
    load_song(3, 5, 7);
    run_song("loop", 2, 50, 45, -1, 0, 0);
`endif

    for (int s = 0; s < 16; s++) begin
      len = $urandom_range(1, 6);
      for (int a = 0; a < len; a++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      code = 0;
        else if (r < 25) code = 31;
        else             code = $urandom_range(1, 30);
        load_word(a, code);
      end
      run_song($sformatf("rand%0d", s), len, 55, 50, -1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/music_seq_ctrl.md
# music_seq_ctrl

Playback sequencer and port arbiter for the beeper's note-store RAM. It walks the stored note codes from address 0, holds each note for a fixed beat, and inserts an articulation gap between notes. It also shares the RAM write port with a note loader, giving the sequencer's read-fetch cycle priority. It sits between the note RAM and the beeper tone generator, which consumes `note`/`note_valid`.

## Interface

- `DATA_WDTH`, 5, note code width; must match the RAM.
- `COL`, 100, RAM depth in entries.
- `COL_BITS`, 8, address width.
- `BEAT_CNT`, 3000000, clock cycles a note is held (≥1).
- `GAP_CNT`, 300000, silent cycles after each note (0 = no gap).

Ports:

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins playback from address 0.
- `stop` in 1: one-cycle pulse that aborts playback.
- `song_len` in COL_BITS: number of notes to play; sampled at accepted `start`.
- `wr_req` in 1: loader write request.
- `wr_addr` in COL_BITS: loader write address.
- `wr_data` in DATA_WDTH: loader write data.
- `wr_ack` out 1: write performed this cycle (combinational).
- `ram_addra` out COL_BITS: RAM write address, equal to `wr_addr`.
- `ram_dina` out DATA_WDTH: RAM write data, equal to `wr_data`.
- `ram_wen` out 1: RAM write enable, equal to `wr_ack`.
- `ram_addrb` out COL_BITS: RAM read address, equal to the playback pointer.
- `ram_doutb` in DATA_WDTH: RAM registered read data.
- `note` out DATA_WDTH: current note code to the tone generator.
- `note_valid` out 1: tone generator sounds `note`.
- `playing` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at natural end of song.

## Operation

The state machine has five states: IDLE, FETCH, LATCH, HOLD and GAP.

- **IDLE**
  - On `start` with latched `song_len` ≥ 1: clear the pointer, go to FETCH.
  - On `start` with `song_len` = 0: pulse `done` next cycle and stay in IDLE.
- **FETCH**
  - `ram_addrb` = pointer; `ram_wen` is forced to 0.
  - The RAM registers `doutb` at the end of this cycle.
  - Next state: LATCH.
- **LATCH**
  - Capture `ram_doutb` into `note`.
  - If the code is all-ones (end marker), treat it as end of song (see below).
  - Otherwise go to HOLD.
- **HOLD**
  - `note_valid` = 1 for exactly BEAT_CNT cycles.
  - Then go to GAP, or directly to the advance step if GAP_CNT = 0.
- **GAP**
  - `note_valid` = 0 for GAP_CNT cycles, then advance.
- **Advance**
  - If pointer = `song_len`−1, this is end of song.
  - Otherwise increment the pointer and go to FETCH.
- **End of song**: behaviour depends on MUSIC_LOOP_EN (see Configuration).
- **Note code 0** is a rest. It is held like any other note, but `note_valid` stays 0 during its HOLD.
- **Arbitration**
  - `wr_ack` = `wr_req` & (state ≠ FETCH) & !`rst`.
  - The loader must hold `wr_req`, `wr_addr` and `wr_data` stable until it sees `wr_ack`.
  - A write during LATCH is legal, because the RAM holds `doutb` while writing.
  - Writes to an address already being played take effect the next time that address is fetched.
- **Request precedence**
  - `stop` in any state: go to IDLE next cycle, drop `note_valid`, clear the pointer, no `done` pulse.
  - `stop` wins over a simultaneous `start`.
  - `start` while `playing` is ignored.
- **Reset**: `rst` asserted mid-operation aborts immediately with the same effect as `stop`.

## Timing

- Reset values: state IDLE, pointer 0, `note` 0, `note_valid` 0, `playing` 0, `done` 0, `wr_ack` 0.
- From `start` sampled at edge N:
  - FETCH is in cycle N+1.
  - LATCH is in cycle N+2.
  - `note` updates and `note_valid` rises at edge N+3.
- Per-note period: 2 + BEAT_CNT + GAP_CNT cycles.
- `done` is registered and asserts the cycle after the end-of-song decision.
- The beat counter and gap counter are each ⌈log2(max+1)⌉ bits wide and reload on every entry to their state.
- The pointer compare uses the `song_len` value latched at `start`, so later changes to `song_len` have no effect on the running song.

## Configuration

- `MUSIC_LOOP_EN` defined:
  - At end of song, the pointer wraps to 0 and the sequencer goes to FETCH.
  - `done` pulses on each wrap; `playing` stays 1.
  - Only `stop` or `rst` ends playback.
  - An end marker also wraps.
- `MUSIC_LOOP_EN` undefined:
  - At end of song, `done` pulses and the sequencer returns to IDLE.
  - `note_valid` = 0 and `playing` = 0.

## Test plan

Bench parameters for all scenarios: BEAT_CNT=4, GAP_CNT=1, COL=8, COL_BITS=3.

- **Reset**: `rst` pulsed mid-HOLD -> all outputs return to reset values in the same cycle; after release, pointer is 0.
- **Basic playback**: load codes 3,5,7 at addresses 0–2, `song_len`=3, loop off, `start` -> `note`=3,5,7 each with `note_valid` high for 4 cycles and low for 1; a 7-cycle period per note; one `done` pulse; then IDLE.
- **Arbitration**: `wr_req` held continuously during playback -> `wr_ack`=0 exactly in FETCH cycles and 1 in all other cycles. Writing 9 to address 2 while address 0 plays -> the third note is 9.
- **End marker and rest**: codes 4,0,31 with `song_len`=3 -> `note` 4 sounds, then a 4-cycle rest with `note_valid` 0, then `done` at the marker without sounding 31.
- **Stop and precedence**: `stop` in the cycle after the first `note_valid` rise -> IDLE next cycle, no `done`. `start` and `stop` in the same cycle -> stays IDLE. `start` with `song_len`=0 -> `done` only.
- **Loop build**: with `MUSIC_LOOP_EN`, `song_len`=2 -> `note` sequence 3,5,3,5…, `done` pulses every 14 cycles, `playing` stays 1 until `stop`.
